lid_motion_ctrl: RTL and testbench

- Command sequencer directly upstream of the lid stepper interface; drives its direction, en and mode inputs.
- Turns single-cycle open/close/stop requests into a bounded move of TRAVEL_STEPS motor steps.
- Tracks lid position by counting step periods in the system clock domain and reports open/closed/busy status to the toybox top-level FSM.

---
 rtl/lid_motion_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_lid_motion_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lid_motion_ctrl.sv
// rtl/lid_motion_ctrl.sv - lid open/close sequencer driving the stepper interface
module lid_motion_ctrl #(
  parameter int unsigned STEP_TICKS   = 600002,
  parameter int unsigned TRAVEL_STEPS = 512,
  parameter int unsigned RAMP_STEPS   = 32,
  parameter int unsigned SETTLE_TICKS = 5000000,
  parameter logic        OPEN_DIR     = 1'b0,
  parameter int unsigned POS_W        = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_open,
  input  logic             cmd_close,
  input  logic             cmd_stop,
  output logic             motor_en,
  output logic             motor_dir,
  output logic [1:0]       motor_mode,
  output logic [POS_W-1:0] position,
  output logic             is_open,
  output logic             is_closed,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TICK_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned SETL_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);
  localparam logic [SETL_W-1:0] SETL_LAST = SETL_W'(SETTLE_TICKS - 1);
  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(TRAVEL_STEPS);
  localparam logic [POS_W-1:0]  RAMP_LO   = POS_W'(RAMP_STEPS);
  localparam logic [POS_W-1:0]  RAMP_HI   = POS_W'(TRAVEL_STEPS - RAMP_STEPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPENING,
    S_CLOSING,
    S_SETTLE
  } state_e;

  typedef enum logic [1:0] {
    P_NONE,
    P_OPEN,
    P_CLOSE
  } pend_e;

  state_e            state_q, state_d;
  pend_e             pend_q, pend_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SETL_W-1:0] settle_q, settle_d;

  logic       motor_en_q, motor_en_d;
  logic       motor_dir_q, motor_dir_d;
  logic [1:0] motor_mode_q, motor_mode_d;
  logic       busy_q, busy_d;
  logic       is_open_q, is_open_d;
  logic       is_closed_q, is_closed_d;
  logic       done_q, done_d;

  // Sequencer: command arbitration (stop > close > open), step counting and settle dwell.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pos_d    = pos_q;
    tick_d   = tick_q;
    settle_d = settle_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        pend_d = P_NONE;
        if (cmd_stop) begin
          state_d = S_IDLE;
        end else if (cmd_close && (pos_q != '0)) begin
          state_d = S_CLOSING;
          tick_d  = '0;
        end else if (cmd_open && (pos_q != POS_MAX)) begin
          state_d = S_OPENING;
          tick_d  = '0;
        end
      end

      S_OPENING: begin
        if (cmd_stop || cmd_close) begin
          // Interruption discards the partial step; the lid is held where it is.
          state_d  = S_SETTLE;
          pend_d   = cmd_stop ? P_NONE : P_CLOSE;
          settle_d = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          pos_d  = pos_q + 1'b1;
          if (pos_d == POS_MAX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      S_CLOSING: begin
        if (cmd_stop || cmd_open) begin
          state_d  = S_SETTLE;
          pend_d   = cmd_stop ? P_NONE : P_OPEN;
          settle_d = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          pos_d  = pos_q - 1'b1;
          if (pos_d == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      S_SETTLE: begin
        if (cmd_stop) begin
          pend_d = P_NONE;
        end else if (cmd_close) begin
          pend_d = P_CLOSE;
        end else if (cmd_open) begin
          pend_d = P_OPEN;
        end
        if (settle_q == SETL_LAST) begin
          // A pending move already satisfied by the position resolves to IDLE.
          if ((pend_d == P_OPEN) && (pos_q != POS_MAX)) begin
            state_d = S_OPENING;
            tick_d  = '0;
          end else if ((pend_d == P_CLOSE) && (pos_q != '0)) begin
            state_d = S_CLOSING;
            tick_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
          pend_d = P_NONE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        pend_d  = P_NONE;
      end
    endcase
  end

  // Output decode from next-state values so every output leaves a flop.
  always_comb begin
    motor_en_d   = (state_d == S_OPENING) || (state_d == S_CLOSING);
    motor_dir_d  = motor_dir_q;
    if (state_d == S_OPENING) begin
      motor_dir_d = OPEN_DIR;
    end else if (state_d == S_CLOSING) begin
      motor_dir_d = ~OPEN_DIR;
    end
    motor_mode_d = ((pos_d < RAMP_LO) || (pos_d > RAMP_HI)) ? 2'b00 : 2'b01;
    busy_d       = (state_d != S_IDLE);
    is_open_d    = (state_d == S_IDLE) && (pos_d == POS_MAX);
    is_closed_d  = (state_d == S_IDLE) && (pos_d == '0);
  end

  // State and output registers; reset defines the lid as closed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pend_q       <= P_NONE;
      pos_q        <= '0;
      tick_q       <= '0;
      settle_q     <= '0;
      motor_en_q   <= 1'b0;
      motor_dir_q  <= ~OPEN_DIR;
      motor_mode_q <= 2'b00;
      busy_q       <= 1'b0;
      is_open_q    <= 1'b0;
      is_closed_q  <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pos_q        <= pos_d;
      tick_q       <= tick_d;
      settle_q     <= settle_d;
      motor_en_q   <= motor_en_d;
      motor_dir_q  <= motor_dir_d;
      motor_mode_q <= motor_mode_d;
      busy_q       <= busy_d;
      is_open_q    <= is_open_d;
      is_closed_q  <= is_closed_d;
      done_q       <= done_d;
    end
  end

  assign motor_en   = motor_en_q;
  assign motor_dir  = motor_dir_q;
  assign motor_mode = motor_mode_q;
  assign position   = pos_q;
  assign busy       = busy_q;
  assign is_open    = is_open_q;
  assign is_closed  = is_closed_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lid_motion_ctrl.sv
// tb/tb_lid_motion_ctrl.sv - scoreboard bench for lid_motion_ctrl
module tb_lid_motion_ctrl;

  localparam int POS_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_open = 1'b0;
  logic             cmd_close = 1'b0;
  logic             cmd_stop = 1'b0;
  logic             motor_en;
  logic             motor_dir;
  logic [1:0]       motor_mode;
  logic [POS_W-1:0] position;
  logic             is_open;
  logic             is_closed;
  logic             busy;
  logic             done;

  lid_motion_ctrl #(
    .STEP_TICKS  (4),
    .TRAVEL_STEPS(8),
    .RAMP_STEPS  (2),
    .SETTLE_TICKS(3),
    .OPEN_DIR    (1'b0),
    .POS_W       (POS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_open  (cmd_open),
    .cmd_close (cmd_close),
    .cmd_stop  (cmd_stop),
    .motor_en  (motor_en),
    .motor_dir (motor_dir),
    .motor_mode(motor_mode),
    .position  (position),
    .is_open   (is_open),
    .is_closed (is_closed),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {SIG_EN, SIG_DIR, SIG_MODE, SIG_POS, SIG_BUSY, SIG_OPEN, SIG_CLOSED} sig_e;

  typedef struct {
    int    at;
    sig_e  sel;
    int    val;
    string name;
  } exp_t;

  exp_t  sb[$];
  int    done_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    mode_tab[0:8];
  event  sample_now;

  function automatic int sig_val(sig_e s);
    case (s)
      SIG_EN:     return int'(motor_en);
      SIG_DIR:    return int'(motor_dir);
      SIG_MODE:   return int'(motor_mode);
      SIG_POS:    return int'(position);
      SIG_BUSY:   return int'(busy);
      SIG_OPEN:   return int'(is_open);
      SIG_CLOSED: return int'(is_closed);
      default:    return -1;
    endcase
  endfunction

  task automatic expect_at(input int at, input sig_e sel, input int val, input string name);
    exp_t e;
    int   i;
    e.at = at;
    e.sel = sel;
    e.val = val;
    e.name = name;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic o, input logic c, input logic s);
    cmd_open  = o;
    cmd_close = c;
    cmd_stop  = s;
    @(negedge clk);
    #1;
    cmd_open  = 1'b0;
    cmd_close = 1'b0;
    cmd_stop  = 1'b0;
  endtask

  // Monitor: pops scheduled expectations and checks every done pulse against the done queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_now);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (e.at != cyc) begin
          n_fail++;
          $display("FAIL %s: scheduled cycle %0d not sampled (now %0d)", e.name, e.at, cyc);
        end else if (sig_val(e.sel) != e.val) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %0d, expected %0d", e.name, cyc, sig_val(e.sel), e.val);
        end
      end
      if (!rst) begin
        while (done_q.size() > 0 && done_q[0] < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_missing: expected pulse at cycle %0d, got none", done_q.pop_front());
        end
        if (done === 1'b1) begin
          n_checks++;
          if (done_q.size() > 0 && done_q[0] == cyc) begin
            void'(done_q.pop_front());
          end else begin
            n_fail++;
            $display("FAIL done_unexpected @cycle %0d: got 1, expected 0", cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    mode_tab = '{0, 0, 1, 1, 1, 1, 1, 0, 0};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    b = cyc;
    expect_at(b + 1, SIG_EN, 0, "rst_en");
    expect_at(b + 1, SIG_DIR, 1, "rst_dir");
    expect_at(b + 1, SIG_MODE, 0, "rst_mode");
    expect_at(b + 1, SIG_POS, 0, "rst_pos");
    expect_at(b + 1, SIG_CLOSED, 1, "rst_closed");
    expect_at(b + 1, SIG_OPEN, 0, "rst_open");
    expect_at(b + 1, SIG_BUSY, 0, "rst_busy");
    tick_to(b + 2);

    // Full open, with mode checked at every position
    b = cyc;
    expect_at(b + 1, SIG_EN, 1, "open_en");
    expect_at(b + 1, SIG_DIR, 0, "open_dir");
    expect_at(b + 1, SIG_BUSY, 1, "open_busy");
    expect_at(b + 1, SIG_CLOSED, 0, "open_closed");
    expect_at(b + 1, SIG_MODE, 0, "open_mode0");
    expect_at(b + 4, SIG_POS, 0, "open_pos_pre1");
    for (int k = 1; k <= 8; k++) begin
      expect_at(b + 1 + 4 * k, SIG_POS, k, "open_pos");
      expect_at(b + 1 + 4 * k, SIG_MODE, mode_tab[k], "open_mode");
    end
    expect_at(b + 33, SIG_EN, 0, "open_end_en");
    expect_at(b + 33, SIG_OPEN, 1, "open_end_isopen");
    expect_at(b + 33, SIG_BUSY, 0, "open_end_busy");
    done_q.push_back(b + 33);
    drive(1'b1, 1'b0, 1'b0);
    tick_to(b + 36);

    // Full close from open
    b = cyc;
    expect_at(b + 1, SIG_EN, 1, "close_en");
    expect_at(b + 1, SIG_DIR, 1, "close_dir");
    expect_at(b + 1, SIG_OPEN, 0, "close_isopen");
    for (int j = 1; j <= 8; j++) begin
      expect_at(b + 1 + 4 * j, SIG_POS, 8 - j, "close_pos");
    end
    expect_at(b + 33, SIG_EN, 0, "close_end_en");
    expect_at(b + 33, SIG_CLOSED, 1, "close_end_closed");
    done_q.push_back(b + 33);
    drive(1'b0, 1'b1, 1'b0);
    tick_to(b + 36);

    // Close while already closed is ignored
    b = cyc;
    expect_at(b + 1, SIG_BUSY, 0, "nop_busy");
    expect_at(b + 1, SIG_EN, 0, "nop_en");
    expect_at(b + 2, SIG_POS, 0, "nop_pos");
    drive(1'b0, 1'b1, 1'b0);
    tick_to(b + 3);

    // Reversal at position 3
    b = cyc;
    expect_at(b + 13, SIG_POS, 3, "rev_pos3");
    for (int t = 14; t <= 16; t++) begin
      expect_at(b + t, SIG_EN, 0, "rev_settle_en");
      expect_at(b + t, SIG_POS, 3, "rev_settle_pos");
      expect_at(b + t, SIG_BUSY, 1, "rev_settle_busy");
    end
    expect_at(b + 17, SIG_EN, 1, "rev_close_en");
    expect_at(b + 17, SIG_DIR, 1, "rev_close_dir");
    expect_at(b + 21, SIG_POS, 2, "rev_pos2");
    expect_at(b + 29, SIG_POS, 0, "rev_pos0");
    expect_at(b + 29, SIG_CLOSED, 1, "rev_closed");
    done_q.push_back(b + 29);
    drive(1'b1, 1'b0, 1'b0);
    tick_to(b + 13);
    drive(1'b0, 1'b1, 1'b0);
    tick_to(b + 32);

    // Repeated open mid-move, then stop+open at 5, then open+close selects close
    b = cyc;
    expect_at(b + 5, SIG_POS, 1, "rep_pos1");
    expect_at(b + 8, SIG_EN, 1, "rep_en");
    expect_at(b + 9, SIG_POS, 2, "rep_phase_pos2");
    expect_at(b + 21, SIG_POS, 5, "stop_pos5");
    expect_at(b + 22, SIG_EN, 0, "stop_en");
    expect_at(b + 22, SIG_BUSY, 1, "stop_busy");
    expect_at(b + 22, SIG_MODE, 1, "stop_mode");
    expect_at(b + 24, SIG_BUSY, 1, "stop_busy_last");
    expect_at(b + 25, SIG_BUSY, 0, "stop_idle");
    expect_at(b + 25, SIG_POS, 5, "stop_pos_held");
    expect_at(b + 25, SIG_OPEN, 0, "stop_isopen");
    expect_at(b + 25, SIG_CLOSED, 0, "stop_isclosed");
    expect_at(b + 27, SIG_EN, 1, "prio_en");
    expect_at(b + 27, SIG_DIR, 1, "prio_dir");
    expect_at(b + 31, SIG_POS, 4, "prio_pos4");
    expect_at(b + 47, SIG_POS, 0, "prio_pos0");
    expect_at(b + 47, SIG_CLOSED, 1, "prio_closed");
    done_q.push_back(b + 47);
    drive(1'b1, 1'b0, 1'b0);
    tick_to(b + 7);
    drive(1'b1, 1'b0, 1'b0);
    tick_to(b + 21);
    drive(1'b1, 1'b0, 1'b1);
    tick_to(b + 26);
    drive(1'b1, 1'b1, 1'b0);
    tick_to(b + 50);

    // Asynchronous reset mid-move at position 4
    b = cyc;
    expect_at(b + 17, SIG_POS, 4, "arst_pos4");
    drive(1'b1, 1'b0, 1'b0);
    tick_to(b + 18);
    rst = 1'b1;
    #1;
    expect_at(cyc, SIG_EN, 0, "arst_en");
    expect_at(cyc, SIG_POS, 0, "arst_pos");
    expect_at(cyc, SIG_CLOSED, 1, "arst_closed");
    expect_at(cyc, SIG_BUSY, 0, "arst_busy");
    expect_at(cyc, SIG_DIR, 1, "arst_dir");
    ->sample_now;
    #1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    b = cyc;
    expect_at(b + 1, SIG_BUSY, 0, "post_rst_busy");
    expect_at(b + 1, SIG_CLOSED, 1, "post_rst_closed");
    tick_to(b + 4);

    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never sampled", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end
    while (done_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_missing: expected pulse at cycle %0d, got none", done_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
